// File: rtl/interp_timing_ctrl_pkg.sv
// Shared definitions for the symbol-timing controller: default widths,
// the fractional format constant and the controller FSM encoding.
package interp_timing_ctrl_pkg;

  // Sample / mu / NCO / step width and the nominal NCO step (0.5 in Q0.W).
  localparam int W_DEF = 19;
  localparam logic [W_DEF-1:0] NOM_W_DEF = 19'h40000;

  // 1.0 in the Q0.W format; one bit wider than the format itself.
  localparam logic [W_DEF:0] ONE = {1'b1, {W_DEF{1'b0}}};

  // Controller states. busy is simply "state is not IDLE".
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/interp_timing_ctrl_div.sv
// Serial restoring fractional divider: quot = floor(dividend * 2^W / divisor),
// one quotient bit per clock, MSB first, W iterations.
//
// Handshake: start_i is a single-cycle request that is only honoured when
// the caller knows the divider is idle; it latches the operands. last_o is
// high during the cycle in which the final quotient bit is produced, so
// quot_o holds the complete result from the following cycle until the next
// start_i. The caller guarantees dividend_i < divisor_i and divisor_i != 0.
module serial_frac_div #(
  parameter int W = 19
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         last_o,
  output logic [W-1:0] quot_o
);

  localparam int CW = $clog2(W);

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  div_q;
  logic [W-1:0]  quot_q;

  logic [W:0]    rem_sh;
  logic          ge;
  logic [W-1:0]  rem_sub;

  // Trial subtraction of the shifted partial remainder. The remainder is
  // always below the divisor, so the difference fits back into W bits.
  always_comb begin
    rem_sh  = {rem_q, 1'b0};
    ge      = (rem_sh >= {1'b0, div_q});
    rem_sub = rem_sh[W-1:0] - div_q;
  end

  // Operand latch, one restoring step per cycle, and the iteration counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= dividend_i;
      div_q  <= divisor_i;
      quot_q <= '0;
    end else if (run_q) begin
      rem_q  <= ge ? rem_sub : rem_sh[W-1:0];
      quot_q <= {quot_q[W-2:0], ge};
      cnt_q  <= cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        run_q <= 1'b0;
      end
    end
  end

  assign last_o = run_q && (cnt_q == CW'(W - 1));
  assign quot_o = quot_q;

endmodule

// File: rtl/interp_timing_ctrl.sv
// Symbol-timing controller: a modulo-1 decrementing NCO stepped by the
// nominal step plus the loop-filter correction. Each NCO underflow pulses
// strobe and, if the divider is free, computes mu = eta / w for the
// interpolator.
module interp_timing_ctrl
  import interp_timing_ctrl_pkg::*;
#(
  parameter int          W     = W_DEF,
  parameter logic [W-1:0] NOM_W = W'(NOM_W_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         smp_valid,
  input  logic [W-1:0] loop_v,
  output logic         strobe,
  output logic [W-1:0] mu,
  output logic         mu_valid,
  output logic         busy,
  output logic         overrun,
  output logic [1:0]   dbg_state
);

  // 1.0 at the configured width; steps at or above it saturate to 1 - 2^-W.
  localparam logic [W+1:0] STEP_LIM = (W == W_DEF) ? (W+2)'(ONE)
                                                   : ((W+2)'(1) << W);

  state_e        state_q, state_d;
  logic [W-1:0]  eta_q;
  logic [W-1:0]  mu_q, mu_d;
  logic          mu_valid_q, mu_valid_d;
  logic          strobe_q;
  logic          overrun_q;

  logic [W+1:0]  step_raw;
  logic [W-1:0]  w_step;
  logic          underflow;
  logic          div_start;
  logic          div_last;
  logic [W-1:0]  div_quot;

  // Step = nominal + signed correction, clamped to [1, 2^W-1] so the
  // divider never sees a zero divisor. Two guard bits keep the sum exact.
  always_comb begin
    step_raw = {2'b00, NOM_W} + {{2{loop_v[W-1]}}, loop_v};
    w_step   = step_raw[W-1:0];
    if (step_raw[W+1] || (step_raw == '0)) begin
      w_step = W'(1);
    end else if (step_raw >= STEP_LIM) begin
      w_step = '1;
    end
  end

  assign underflow = smp_valid && (eta_q < w_step);
  assign div_start = underflow && (state_q == ST_IDLE);

  // NCO: decrements modulo 2^W on every sample, independent of the divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eta_q <= '1;
    end else if (smp_valid) begin
      eta_q <= eta_q - w_step;
    end
  end

  serial_frac_div #(
    .W (W)
  ) u_div (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (div_start),
    .dividend_i (eta_q),
    .divisor_i  (w_step),
    .last_o     (div_last),
    .quot_o     (div_quot)
  );

  // Controller state, mu output register, strobe and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mu_q       <= '0;
      mu_valid_q <= 1'b0;
      strobe_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mu_q       <= mu_d;
      mu_valid_q <= mu_valid_d;
      strobe_q   <= underflow;
      overrun_q  <= overrun_q | (underflow && (state_q != ST_IDLE));
    end
  end

  // Next-state logic: IDLE waits for an underflow, DIV waits for the last
  // quotient bit, DONE publishes mu for one cycle.
  always_comb begin
    state_d    = state_q;
    mu_d       = mu_q;
    mu_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: if (underflow) state_d = ST_DIV;
      ST_DIV:  if (div_last)  state_d = ST_DONE;
      ST_DONE: begin
        mu_d       = div_quot;
        mu_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign strobe    = strobe_q;
  assign mu        = mu_q;
  assign mu_valid  = mu_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
